// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register with bit counter, busy/done status and a
// sticky error flag for shift requests that arrive with nothing left to send.
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    remaining,
    output logic             err
);

    typedef enum logic {
        IDLE     = 1'b0,
        SHIFTING = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic             shift_active;
    logic             last_bit;

    assign shift_active = shift && !load && (state == SHIFTING);
    assign last_bit     = shift_active && (remaining == CW'(1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = SHIFTING;
        end else if (last_bit) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        sreg_shifted = sreg;
        if (MSB_FIRST) begin
            sreg_shifted = {sreg[WIDTH-2:0], sin};
        end else begin
            sreg_shifted = {sin, sreg[WIDTH-1:1]};
        end
    end

    // Load aborts any word in flight; no done pulse is produced for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            remaining <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (load) begin
            sreg      <= din;
            remaining <= CW'(WIDTH);
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (shift) begin
            if (state == SHIFTING) begin
                sreg      <= sreg_shifted;
                remaining <= remaining - CW'(1);
                done      <= last_bit;
            end else begin
                err  <= 1'b1;
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

    always_comb begin
        out  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        busy = (state == SHIFTING);
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg: a 4-bit MSB-first instance and an 8-bit
// LSB-first instance driven from hand-computed vector tables plus reset sequences.
module tb_piso_shift_reg;

    typedef struct {
        string      name;
        logic       which;     // 0: 4-bit MSB-first, 1: 8-bit LSB-first
        logic       load;
        logic       shift;
        logic       sin;
        logic [7:0] din;
        logic       exp_out;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_err;
        logic [3:0] exp_rem;
    } vec_t;

    logic       clk;
    logic       rst_n;

    logic [3:0] a_din;
    logic       a_load, a_shift, a_sin;
    logic       a_out, a_busy, a_done, a_err;
    logic [2:0] a_rem;

    logic [7:0] b_din;
    logic       b_load, b_shift, b_sin;
    logic       b_out, b_busy, b_done, b_err;
    logic [3:0] b_rem;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(a_din), .load(a_load), .shift(a_shift),
        .sin(a_sin), .out(a_out), .busy(a_busy), .done(a_done),
        .remaining(a_rem), .err(a_err)
    );

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(b_din), .load(b_load), .shift(b_shift),
        .sin(b_sin), .out(b_out), .busy(b_busy), .done(b_done),
        .remaining(b_rem), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {out, busy, done, err, remaining[3:0]}
    function automatic logic [7:0] obs(input logic which);
        if (which) return {b_out, b_busy, b_done, b_err, b_rem};
        return {a_out, a_busy, a_done, a_err, 1'b0, a_rem};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {out,busy,done,err,rem}=%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
                     name, act[7], act[6], act[5], act[4], act[3:0],
                     exp[7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic add(input string name, input logic which, input logic load,
                       input logic shift, input logic sin, input logic [7:0] din,
                       input logic o, input logic b, input logic d, input logic e,
                       input logic [3:0] r);
        vec_t v;
        v.name = name; v.which = which; v.load = load; v.shift = shift; v.sin = sin;
        v.din = din; v.exp_out = o; v.exp_busy = b; v.exp_done = d; v.exp_err = e;
        v.exp_rem = r;
        vecs.push_back(v);
    endtask

    // Drive at a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic apply(input logic which, input logic load, input logic shift,
                         input logic sin, input logic [7:0] din);
        a_load = 1'b0; a_shift = 1'b0; a_sin = 1'b0; a_din = '0;
        b_load = 1'b0; b_shift = 1'b0; b_sin = 1'b0; b_din = '0;
        if (which) begin
            b_load = load; b_shift = shift; b_sin = sin; b_din = din;
        end else begin
            a_load = load; a_shift = shift; a_sin = sin; a_din = din[3:0];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // 4-bit MSB-first, sin=0: load 1010 then four shifts
        add("a_load_1010", 0, 1, 0, 0, 8'h0A, 1, 1, 0, 0, 4);
        add("a_shift1",    0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 3);
        add("a_shift2",    0, 0, 1, 0, 8'h00, 1, 1, 0, 0, 2);
        add("a_shift3",    0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 1);
        add("a_shift4",    0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0);
        add("a_done_drop", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        // load and shift together: load wins, then hold
        add("a_ld_sh",     0, 1, 1, 0, 8'h0A, 1, 1, 0, 0, 4);
        add("a_hold1",     0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 4);
        add("a_hold2",     0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 4);
        // load 1100, two shifts, reload 0011 mid-word
        add("a_load_1100", 0, 1, 0, 0, 8'h0C, 1, 1, 0, 0, 4);
        add("a_p_shift1",  0, 0, 1, 0, 8'h00, 1, 1, 0, 0, 3);
        add("a_p_shift2",  0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 2);
        add("a_reload",    0, 1, 0, 0, 8'h03, 0, 1, 0, 0, 4);
        add("a_r_shift1",  0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 3);
        add("a_r_shift2",  0, 0, 1, 0, 8'h00, 1, 1, 0, 0, 2);
        add("a_r_shift3",  0, 0, 1, 0, 8'h00, 1, 1, 0, 0, 1);
        add("a_r_shift4",  0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0);
        // shift while idle: sticky err, no underflow
        add("a_idle_sh",   0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0);
        add("a_err_hold",  0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0);
        add("a_idle_sh2",  0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0);
        add("a_err_clr",   0, 1, 0, 0, 8'h0A, 1, 1, 0, 0, 4);
        // 8-bit LSB-first, sin=1: load A5 then eight shifts, then back-to-back load
        add("b_load_a5",   1, 1, 0, 1, 8'hA5, 1, 1, 0, 0, 8);
        add("b_shift1",    1, 0, 1, 1, 8'h00, 0, 1, 0, 0, 7);
        add("b_shift2",    1, 0, 1, 1, 8'h00, 1, 1, 0, 0, 6);
        add("b_shift3",    1, 0, 1, 1, 8'h00, 0, 1, 0, 0, 5);
        add("b_shift4",    1, 0, 1, 1, 8'h00, 0, 1, 0, 0, 4);
        add("b_shift5",    1, 0, 1, 1, 8'h00, 1, 1, 0, 0, 3);
        add("b_shift6",    1, 0, 1, 1, 8'h00, 0, 1, 0, 0, 2);
        add("b_shift7",    1, 0, 1, 1, 8'h00, 1, 1, 0, 0, 1);
        add("b_shift8",    1, 0, 1, 1, 8'h00, 1, 0, 1, 0, 0);
        add("b_b2b_load",  1, 1, 0, 1, 8'h3C, 0, 1, 0, 0, 8);
        add("b_b2b_shift", 1, 0, 1, 1, 8'h00, 0, 1, 0, 0, 7);

        rst_n = 1'b0;
        a_load = 1'b0; a_shift = 1'b0; a_sin = 1'b0; a_din = '0;
        b_load = 1'b0; b_shift = 1'b0; b_sin = 1'b0; b_din = '0;
        #12;
        check("a_reset", obs(1'b0), 8'h00);
        check("b_reset", obs(1'b1), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            apply(vecs[i].which, vecs[i].load, vecs[i].shift, vecs[i].sin, vecs[i].din);
            check(vecs[i].name, obs(vecs[i].which),
                  {vecs[i].exp_out, vecs[i].exp_busy, vecs[i].exp_done,
                   vecs[i].exp_err, vecs[i].exp_rem});
        end

        // Asynchronous reset in the middle of a word
        apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h0F);
        check("a_load_1111", obs(1'b0), {1'b1, 1'b1, 1'b0, 1'b0, 4'd4});
        apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("a_mid_shift", obs(1'b0), {1'b1, 1'b1, 1'b0, 1'b0, 4'd3});
        #2 rst_n = 1'b0;
        #1 check("a_async_rst", obs(1'b0), 8'h00);
        check("b_async_rst", obs(1'b1), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("a_post_rst_sh", obs(1'b0), {1'b0, 1'b0, 1'b0, 1'b1, 4'd0});

        // Async reset must also clear a set err flag
        apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        check("b_idle_err", obs(1'b1), {1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
        #2 rst_n = 1'b0;
        #1 check("a_err_rst", obs(1'b0), 8'h00);
        check("b_err_rst", obs(1'b1), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
